// File: rtl/z80_ind16_load_sequencer.sv
// z80_ind16_load_sequencer
//   Sequences the Z80 "LD dd,(nn)" (ED 01dd1011 nn_lo nn_hi) instruction:
//   fetches the prefix, opcode and 16-bit operand address, reads the 16-bit
//   word at nn/nn+1 and issues a single register-pair write strobe.
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : asynchronous active-high reset
//   start      : begin a sequence at pc_in (sampled only while idle)
//   pc_in      : address of the ED prefix byte
//   mem_req    : read request, held until mem_ack
//   mem_addr   : read address, stable while mem_req is high
//   mem_ack    : read complete, mem_rdata valid in the same cycle
//   mem_rdata  : read data byte
//   reg_we     : one-cycle register-pair write strobe
//   reg_wnum   : register-pair number {2'b10, dd}
//   reg_wdata  : loaded word {(nn+1), (nn)}
//   pc_out     : pc_in + 4, valid while done is high
//   busy       : high whenever a sequence is in progress
//   done       : one-cycle pulse on successful completion
//   illegal    : one-cycle pulse on prefix/opcode decode failure
//   timeout    : one-cycle pulse when a read waits ACK_TIMEOUT cycles unacked
//
// Parameter
//   ACK_TIMEOUT : cycles a request may wait for mem_ack before aborting;
//                 0 disables the timeout.

`timescale 1ns/1ps

module z80_ind16_load_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] pc_in,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        reg_we,
  output logic [3:0]  reg_wnum,
  output logic [15:0] reg_wdata,
  output logic [15:0] pc_out,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        timeout
);

  // The wait counter only ever holds 0 .. ACK_TIMEOUT-1: the abort fires on
  // the cycle the counter would step past its last value.
  localparam int unsigned WW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam bit          TO_EN = (ACK_TIMEOUT != 0);
  localparam logic [WW-1:0] WAIT_LAST = (ACK_TIMEOUT == 0) ? '0 : WW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_F_PFX,
    S_F_OP,
    S_F_NL,
    S_F_NH,
    S_R_LO,
    S_R_HI,
    S_WB
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   pc_q, pc_d;
  logic [1:0]    dd_q, dd_d;
  logic [15:0]   nn_q, nn_d;
  logic [7:0]    lo_q, lo_d;
  logic [7:0]    hi_q, hi_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          illegal_q, illegal_d;
  logic          timeout_q, timeout_d;
  logic          req;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      dd_q      <= '0;
      nn_q      <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      dd_q      <= dd_d;
      nn_q      <= nn_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    req = (state_q == S_F_PFX) || (state_q == S_F_OP) || (state_q == S_F_NL) ||
          (state_q == S_F_NH)  || (state_q == S_R_LO) || (state_q == S_R_HI);
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    dd_d      = dd_q;
    nn_d      = nn_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    wait_d    = '0;
    illegal_d = 1'b0;
    timeout_d = 1'b0;

    if (req && !mem_ack) begin
      // Stalled read: hold address and request, count toward the abort.
      if (TO_EN) begin
        if (wait_q == WAIT_LAST) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
    end else begin
      // Either not requesting, or the read was acknowledged this cycle
      // (an ack on the last allowed cycle still counts as success).
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            pc_d    = pc_in;
            state_d = S_F_PFX;
          end
        end
        S_F_PFX: begin
          if (mem_rdata == 8'hED) begin
            state_d = S_F_OP;
          end else begin
            state_d   = S_IDLE;
            illegal_d = 1'b1;
          end
        end
        S_F_OP: begin
          if ((mem_rdata[7:6] == 2'b01) && (mem_rdata[3:0] == 4'b1011)) begin
            dd_d    = mem_rdata[5:4];
            state_d = S_F_NL;
          end else begin
            state_d   = S_IDLE;
            illegal_d = 1'b1;
          end
        end
        S_F_NL: begin
          nn_d[7:0] = mem_rdata;
          state_d   = S_F_NH;
        end
        S_F_NH: begin
          nn_d[15:8] = mem_rdata;
          state_d    = S_R_LO;
        end
        S_R_LO: begin
          lo_d    = mem_rdata;
          state_d = S_R_HI;
        end
        S_R_HI: begin
          hi_d    = mem_rdata;
          state_d = S_WB;
        end
        S_WB: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req   = req;
    mem_addr  = '0;
    reg_we    = 1'b0;
    done      = 1'b0;
    reg_wnum  = '0;
    reg_wdata = '0;
    pc_out    = '0;
    busy      = (state_q != S_IDLE);
    // Abort pulses are registered, so they appear in the first idle cycle and
    // can never coincide with the write-back strobe.
    illegal   = illegal_q;
    timeout   = timeout_q;

    unique case (state_q)
      S_F_PFX: mem_addr = pc_q;
      S_F_OP:  mem_addr = pc_q + 16'd1;
      S_F_NL:  mem_addr = pc_q + 16'd2;
      S_F_NH:  mem_addr = pc_q + 16'd3;
      S_R_LO:  mem_addr = nn_q;
      S_R_HI:  mem_addr = nn_q + 16'd1;
      S_WB: begin
        reg_we    = 1'b1;
        done      = 1'b1;
        reg_wnum  = {2'b10, dd_q};
        reg_wdata = {hi_q, lo_q};
        pc_out    = pc_q + 16'd4;
      end
      default: ;
    endcase
  end

endmodule
